shift_piso_gen: RTL and testbench

SHIFT_PISO_GEN -- requirements
Module: shift_piso_gen

---
 rtl/shift_piso_gen_if.sv | 34 +++
 rtl/shift_piso_gen.sv | 153 +++++++++++++++
 tb/tb_shift_piso_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_piso_gen_if.sv
// Bus bundle for shift_piso_gen: parallel frame in, serial bit out, frame status.
// SdaIn/Nack exist only when SHIFT_PISO_ACK_EN is defined.
interface shift_piso_gen_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] In;
    logic             Load;
    logic             ShiftEn;
    logic             Out;
    logic             Busy;
    logic             Done;
`ifdef SHIFT_PISO_ACK_EN
    logic             SdaIn;
    logic             Nack;

    modport slave (
        input  In, Load, ShiftEn, SdaIn,
        output Out, Busy, Done, Nack
    );
    modport master (
        output In, Load, ShiftEn, SdaIn,
        input  Out, Busy, Done, Nack
    );
`else
    modport slave (
        input  In, Load, ShiftEn,
        output Out, Busy, Done
    );
    modport master (
        output In, Load, ShiftEn,
        input  Out, Busy, Done
    );
`endif
endinterface

// File: rtl/shift_piso_gen.sv
// Parallel-in serial-out frame shifter (I2C-style SDA driver), one bit per ShiftEn strobe.
// Define SHIFT_PISO_ACK_EN to add an ACK slot that samples SdaIn into Nack.
module shift_piso_gen #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    shift_piso_gen_if.slave   bus
);
    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SHIFT_PISO_ACK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SHIFT_PISO_ACK_EN
    logic             nack_q, nack_d;
`endif

    logic [WIDTH-1:0] shift_next;
    logic             head_bit;
    logic             frame_end;

    // Shift register advanced one place toward the transmit end, zero filled.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shreg_q[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shreg_q[gi+1];
                end
            end
        end
    endgenerate

    assign head_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        frame_end = 1'b0;
`ifdef SHIFT_PISO_ACK_EN
        nack_d    = nack_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    shreg_d = bus.In;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ShiftEn) begin
                    if (cnt_q < CNT_LAST) begin
                        out_d   = head_bit;
                        shreg_d = shift_next;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
`ifdef SHIFT_PISO_ACK_EN
                        // Release SDA so the receiver can drive its ACK bit.
                        out_d   = 1'b1;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ACK;
`else
                        frame_end = 1'b1;
`endif
                    end
                end
            end
`ifdef SHIFT_PISO_ACK_EN
            ACK: begin
                if (bus.ShiftEn) begin
                    nack_d    = bus.SdaIn;
                    frame_end = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A Load arriving with the closing strobe chains straight into the next frame.
        if (frame_end) begin
            out_d  = 1'b1;
            done_d = 1'b1;
            cnt_d  = '0;
            if (bus.Load) begin
                shreg_d = bus.In;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_PISO_ACK_EN
            nack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_PISO_ACK_EN
            nack_q  <= nack_d;
`endif
        end
    end

    assign bus.Out  = out_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
`ifdef SHIFT_PISO_ACK_EN
    assign bus.Nack = nack_q;
`endif

endmodule

// File: tb/tb_shift_piso_gen.sv
// Directed bench for shift_piso_gen: MSB/LSB-first instances share stimulus.
// Builds with or without SHIFT_PISO_ACK_EN; frame endings adapt to the ACK slot.
module tb_shift_piso_gen;
    logic Clk;
    logic Rst;
    int   total;
    int   bad;
    int   done_cnt;

    shift_piso_gen_if #(.WIDTH(8)) b0 ();
    shift_piso_gen_if #(.WIDTH(8)) b1 ();

    assign b1.In      = b0.In;
    assign b1.Load    = b0.Load;
    assign b1.ShiftEn = b0.ShiftEn;
`ifdef SHIFT_PISO_ACK_EN
    assign b1.SdaIn   = b0.SdaIn;
`endif

    shift_piso_gen #(.WIDTH(8), .MSB_FIRST(1)) u_msb (.Clk(Clk), .Rst(Rst), .bus(b0));
    shift_piso_gen #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (.Clk(Clk), .Rst(Rst), .bus(b1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (b0.Done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe();
        b0.ShiftEn = 1'b1;
        tick();
        b0.ShiftEn = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        b0.In   = v;
        b0.Load = 1'b1;
        tick();
        b0.Load = 1'b0;
    endtask

    // Shift out 8 bits of seq (first bit at seq[7]) with 3 idle cycles between strobes.
    task automatic send_bits(input string tag, input logic [7:0] seq);
        for (int k = 0; k < 8; k++) begin
            strobe();
            chk($sformatf("%s_bit%0d", tag, k + 1), 32'(b0.Out), 32'(seq[7-k]));
            chk($sformatf("%s_busy%0d", tag, k + 1), 32'(b0.Busy), 32'd1);
            repeat (3) tick();
            chk($sformatf("%s_hold%0d", tag, k + 1), 32'(b0.Out), 32'(seq[7-k]));
        end
    endtask

    task automatic end_frame(input string tag, input bit ld, input logic [7:0] v, input logic sda);
`ifdef SHIFT_PISO_ACK_EN
        strobe();
        chk({tag, "_ack_out"}, 32'(b0.Out), 32'd1);
        chk({tag, "_ack_done"}, 32'(b0.Done), 32'd0);
        chk({tag, "_ack_busy"}, 32'(b0.Busy), 32'd1);
        tick();
        b0.SdaIn = sda;
`else
        if (sda) begin end
`endif
        b0.Load = ld;
        b0.In   = v;
        strobe();
        b0.Load = 1'b0;
        chk({tag, "_end_out"}, 32'(b0.Out), 32'd1);
        chk({tag, "_end_done"}, 32'(b0.Done), 32'd1);
        chk({tag, "_end_busy"}, 32'(b0.Busy), 32'(ld));
`ifdef SHIFT_PISO_ACK_EN
        chk({tag, "_nack"}, 32'(b0.Nack), 32'(sda));
        b0.SdaIn = 1'b0;
`endif
        tick();
        chk({tag, "_done_clr"}, 32'(b0.Done), 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] msb_c1;
        logic [7:0] lsb_c1;
        total = 0;
        bad = 0;
        done_cnt = 0;
        msb_c1 = 8'b1100_0001;
        lsb_c1 = 8'b1000_0011;
        Rst = 1'b1;
        b0.In = 8'h00;
        b0.Load = 1'b0;
        b0.ShiftEn = 1'b0;
`ifdef SHIFT_PISO_ACK_EN
        b0.SdaIn = 1'b0;
`endif
        tick();
        tick();
        chk("rst_out", 32'(b0.Out), 32'd1);
        chk("rst_busy", 32'(b0.Busy), 32'd0);
        chk("rst_done", 32'(b0.Done), 32'd0);
        Rst = 1'b0;
        tick();

        // ShiftEn alone in IDLE is ignored.
        strobe();
        chk("idle_shift_busy", 32'(b0.Busy), 32'd0);
        chk("idle_shift_out", 32'(b0.Out), 32'd1);

        // 0xC1, Load coinciding with ShiftEn; both bit orders checked in parallel.
        b0.In = 8'hC1;
        b0.Load = 1'b1;
        b0.ShiftEn = 1'b1;
        tick();
        b0.Load = 1'b0;
        b0.ShiftEn = 1'b0;
        chk("c1_load_busy", 32'(b0.Busy), 32'd1);
        chk("c1_load_out", 32'(b0.Out), 32'd1);
        repeat (3) tick();
        for (int k = 0; k < 8; k++) begin
            strobe();
            chk($sformatf("c1_msb_bit%0d", k + 1), 32'(b0.Out), 32'(msb_c1[7-k]));
            chk($sformatf("c1_lsb_bit%0d", k + 1), 32'(b1.Out), 32'(lsb_c1[7-k]));
            chk($sformatf("c1_done%0d", k + 1), 32'(b0.Done), 32'd0);
            repeat (3) tick();
        end
        end_frame("c1", 1'b0, 8'h00, 1'b0);
        chk("c1_lsb_busy", 32'(b1.Busy), 32'd0);
        chk("c1_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back: 0x00 frame, 0xFF loaded on the closing strobe.
        do_load(8'h00);
        send_bits("zero", 8'h00);
        end_frame("chain", 1'b1, 8'hFF, 1'b0);
        chk("chain_busy_after", 32'(b0.Busy), 32'd1);
        send_bits("ones", 8'hFF);
        end_frame("ones", 1'b0, 8'h00, 1'b0);
        chk("chain_done_count", 32'(done_cnt), 32'd3);

        // Mid-frame Load of 0x55 after 3 bits of 0x3C is ignored.
        do_load(8'h3C);
        for (int k = 0; k < 3; k++) strobe();
        chk("mid_bit3", 32'(b0.Out), 32'd1);
        do_load(8'h55);
        chk("mid_load_busy", 32'(b0.Busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            strobe();
            chk($sformatf("mid_bit%0d", k + 4), 32'(b0.Out), 32'((8'h3C >> (4 - k)) & 1));
        end
        end_frame("mid", 1'b0, 8'h00, 1'b0);

        // Reset after 4 bits of 0xC1, asserted together with Load and ShiftEn.
        do_load(8'hC1);
        for (int k = 0; k < 4; k++) strobe();
        chk("rst4_bit4", 32'(b0.Out), 32'd0);
        d0 = done_cnt;
        Rst = 1'b1;
        b0.Load = 1'b1;
        b0.ShiftEn = 1'b1;
        b0.In = 8'h00;
        tick();
        Rst = 1'b0;
        b0.Load = 1'b0;
        b0.ShiftEn = 1'b0;
        chk("rst4_out", 32'(b0.Out), 32'd1);
        chk("rst4_busy", 32'(b0.Busy), 32'd0);
        chk("rst4_done", 32'(b0.Done), 32'd0);
        repeat (2) strobe();
        chk("rst4_idle_busy", 32'(b0.Busy), 32'd0);
        chk("rst4_no_done", 32'(done_cnt - d0), 32'd0);
        do_load(8'h81);
        send_bits("restart", 8'h81);
        end_frame("restart", 1'b0, 8'h00, 1'b0);

`ifdef SHIFT_PISO_ACK_EN
        // 0xA5 with receiver NACK (SdaIn=1) in the ACK slot.
        do_load(8'hA5);
        send_bits("a5", 8'hA5);
        end_frame("a5", 1'b0, 8'h00, 1'b1);
        repeat (3) tick();
        chk("a5_nack_hold", 32'(b0.Nack), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
